roll_display_scan: RTL and testbench
====================================

// Module: roll_display_scan
// PURPOSE
//  Downstream consumer of the SPI receiver's 16-bit roll word. Moves the word from the sck/nss
//  domain into the system clk domain and shows all four hex nybbles on a 4-digit, time-multiplexed,
//  common-anode seven-segment display. Replaces single-digit display of 4 selected roll bits.
// PARAMETERS
//  REFRESH_DIV  10000  clk cycles each digit is lit before the scan advances (>=1)
//  SETTLE_CYC   4      clk cycles between detected nss fall and roll capture (>=1)
//  BLANK_LZ     1      1 = blank leading-zero digits; 0 = always show all four digits
// PORTS
//  clk         in   1   system clock
//  rst         in   1   reset, synchronous, active-high
//  nss_async   in   1   raw SPI chip-select, asynchronous to clk
//  roll_in     in   16  roll word from SPI receiver; changes only on nss falling edge
//  seg         out  7   segments {g,f,e,d,c,b,a}, active-low
//  an          out  4   digit anodes, active-low one-hot; an[0] = least-significant digit
//  roll_valid  out  1   high once at least one roll has been captured
//  new_roll    out  1   one-cycle pulse in the cycle after roll_q updates
// BEHAVIOUR
//  Reset: seg=7'b0111111 (dash), an=4'b1110, roll_valid=0, new_roll=0, roll_q=0, digit index=0,
//   refresh count=0, FSM=WAIT_FALL, synchroniser flops=1 (nss idle-high).
//  CDC: nss_async -> s1 -> s2 (2-FF sync) -> s3 (delay). fall_det = ~s2 & s3. roll_in is only
//   sampled inside CAPTURE; never sampled combinationally elsewhere.
//  Capture FSM:
//   WAIT_FALL: fall_det -> SETTLE, settle count=0.
//   SETTLE: count++ each cycle; fall_det again -> restart count at 0; count==SETTLE_CYC-1 -> CAPTURE.
//   CAPTURE: roll_q<=roll_in, roll_valid<=1, -> WAIT_FALL. new_roll=1 the following cycle only.
//   Latency: roll_q updates SETTLE_CYC+1 clk edges after the edge on which fall_det first goes high.
//  Scan: refresh count 0..REFRESH_DIV-1; on terminal count -> 0 and digit index 0->1->2->3->0.
//   REFRESH_DIV=1 advances every cycle. an = ~(4'b0001 << index), registered, updated with seg.
//  Digit content (registered, one cycle after index change):
//   roll_valid=0 -> dash on every digit.
//   else nybble roll_q[4*i+3:4*i] decoded to hex 0-F (0=7'b1000000, 8=7'b0000000, F=7'b0001110).
//   BLANK_LZ=1: digit i (i>=1) shows 7'b1111111 if all nybbles i..3 are zero; digit 0 never blanked.
//  Boundaries: capture and scan independent; a capture mid-scan changes content on the next digit
//   refresh without resetting index/count. rst mid-SETTLE discards pending capture. nss glitch
//   shorter than 2 clk may be missed (acceptable: roll_in unchanged then). roll_in=0 with BLANK_LZ
//   -> only digit 0 lit showing "0".
// STRUCTURE
//  Shared package roll_pkg: typedef enum logic [1:0] {WAIT_FALL, SETTLE, CAPTURE} cap_state_t;
//   constants SEG_DASH=7'b0111111, SEG_BLANK=7'b1111111; typedef logic [15:0] roll_t.
//  One sub-module: hex7seg (4-bit nybble -> active-low {g..a}, purely combinational, true hex).
//  Top holds synchroniser, capture FSM, scan counter, output registers.
// TESTING (REFRESH_DIV=4, SETTLE_CYC=4 for sim)
//  After rst, no nss activity for 64 cycles -> roll_valid=0, seg=dash on all digits, an cycles
//   1110,1101,1011,0111 each held 4 cycles.
//  roll_in=16'h1A2F, drop nss -> new_roll pulses once, exactly 5 edges after fall_det + 1;
//   digits read F,2,A,1 on an[0..3]; roll_valid=1.
//  BLANK_LZ=1, roll_in=16'h0030 -> an[3],an[2] digits blank, an[1]="3", an[0]="0";
//   roll_in=16'h0000 -> only an[0] lit "0". BLANK_LZ=0 -> all four shown.
//  nss falls, rises, falls again within SETTLE -> single capture of final roll_in value,
//   one new_roll pulse, timed from second fall_det.
//  rst asserted during SETTLE -> no capture, roll_valid=0, all outputs at reset values next cycle.
//  Capture while index=2 mid-refresh -> index/count sequence uninterrupted; new value visible
//   from next digit advance.

Source files
------------

// File: rtl/roll_pkg.sv
// ---------------------------------------------------------------------------
// roll_pkg
// Shared types and constants for the roll display path.
//   cap_state_t : capture FSM states (WAIT_FALL, SETTLE, CAPTURE)
//   roll_t      : 16-bit roll word as delivered by the SPI receiver
//   SEG_DASH    : active-low {g..a} pattern lighting only the g bar
//   SEG_BLANK   : active-low {g..a} pattern with every segment off
// Helpers pick a nybble out of a roll word and test whether a digit is a
// leading zero (it and every more-significant nybble are zero).
// ---------------------------------------------------------------------------
package roll_pkg;

   typedef enum logic [1:0] {
      WAIT_FALL = 2'd0,
      SETTLE    = 2'd1,
      CAPTURE   = 2'd2
   } cap_state_t;

   typedef logic [15:0] roll_t;

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Nybble i of the roll word, i = 0 is the least-significant digit.
   function automatic logic [3:0] nybble_at(input roll_t r, input logic [1:0] i);
      return r[{i, 2'b00} +: 4];
   endfunction

   // True when nybbles i..3 are all zero, i.e. digit i would be a leading zero.
   function automatic logic upper_zero(input roll_t r, input logic [1:0] i);
      logic z;
      case (i)
         2'd0:    z = (r == 16'h0000);
         2'd1:    z = (r[15:4] == 12'h000);
         2'd2:    z = (r[15:8] == 8'h00);
         default: z = (r[15:12] == 4'h0);
      endcase
      return z;
   endfunction

endpackage

// File: rtl/roll_display_scan_hex7seg.sv
// ---------------------------------------------------------------------------
// hex7seg
// Purely combinational hex-digit decoder for a common-anode display.
//   nybble : in  4  value 0..F to show
//   seg    : out 7  segments {g,f,e,d,c,b,a}, active-low
// Letters follow the usual mixed-case hex set (A, b, C, d, E, F) so that
// b/d cannot be confused with 8/0.
// ---------------------------------------------------------------------------
module hex7seg (
   input  logic [3:0] nybble,
   output logic [6:0] seg
);

   // Straight lookup; every case is listed so no latch can be inferred.
   always_comb begin
      seg = 7'b1111111;
      case (nybble)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/roll_display_scan.sv
// ---------------------------------------------------------------------------
// roll_display_scan
// Takes the 16-bit roll word from the SPI receiver (sck/nss domain) into the
// clk domain and shows all four hex nybbles on a 4-digit multiplexed
// common-anode seven-segment display.
//   clk        : in  1   system clock
//   rst        : in  1   synchronous active-high reset
//   nss_async  : in  1   raw SPI chip-select, asynchronous to clk
//   roll_in    : in  16  roll word, only changes around an nss falling edge
//   seg        : out 7   segments {g..a}, active-low
//   an         : out 4   digit anodes, active-low one-hot, an[0] = LS digit
//   roll_valid : out 1   high once any roll has been captured
//   new_roll   : out 1   one-cycle pulse the cycle after roll_q updates
// Parameters:
//   REFRESH_DIV : clk cycles each digit stays lit (>=1)
//   SETTLE_CYC  : clk cycles from detected nss fall to capture (>=1)
//   BLANK_LZ    : 1 blanks leading-zero digits, 0 always shows four digits
// ---------------------------------------------------------------------------
module roll_display_scan
   import roll_pkg::*;
#(
   parameter int REFRESH_DIV = 10000,
   parameter int SETTLE_CYC  = 4,
   parameter int BLANK_LZ    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        nss_async,
   input  logic [15:0] roll_in,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        roll_valid,
   output logic        new_roll
);

   localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

   logic             nss_s1, nss_s2, nss_s3;
   logic             fall_det;
   cap_state_t       state, state_next;
   logic [SET_W-1:0] settle_cnt, settle_next;
   logic             capture_load;
   roll_t            roll_q;
   logic [REF_W-1:0] refresh_cnt;
   logic [1:0]       digit_idx;
   logic             scan_tick;
   logic             load_disp;
   logic [3:0]       cur_nybble;
   logic [6:0]       hex_seg;
   logic [6:0]       digit_seg;

   // Two-flop synchroniser plus one delay stage for edge detection. The
   // flops reset high because nss idles high, so leaving reset never looks
   // like a falling edge while the bus is quiet.
   always_ff @(posedge clk) begin
      if (rst) begin
         nss_s1 <= 1'b1;
         nss_s2 <= 1'b1;
         nss_s3 <= 1'b1;
      end else begin
         nss_s1 <= nss_async;
         nss_s2 <= nss_s1;
         nss_s3 <= nss_s2;
      end
   end

   assign fall_det = ~nss_s2 & nss_s3;

   // Capture FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= WAIT_FALL;
         settle_cnt <= '0;
      end else begin
         state      <= state_next;
         settle_cnt <= settle_next;
      end
   end

   // Capture FSM next state. A fresh falling edge during SETTLE restarts the
   // wait, so a chip-select bounce yields one capture of the final word.
   always_comb begin
      state_next  = state;
      settle_next = settle_cnt;
      case (state)
         WAIT_FALL: begin
            if (fall_det) begin
               state_next  = SETTLE;
               settle_next = '0;
            end
         end
         SETTLE: begin
            if (fall_det) begin
               settle_next = '0;
            end else if (settle_cnt == SET_LAST) begin
               state_next = CAPTURE;
            end else begin
               settle_next = settle_cnt + SET_W'(1);
            end
         end
         CAPTURE: begin
            state_next = WAIT_FALL;
         end
         default: begin
            state_next = WAIT_FALL;
         end
      endcase
   end

   // Capture FSM outputs. The word is loaded on the edge that enters CAPTURE,
   // which puts the update SETTLE_CYC+1 edges after fall_det first rises;
   // the cycle spent in CAPTURE is then exactly the new_roll pulse.
   always_comb begin
      capture_load = (state == SETTLE) && !fall_det && (settle_cnt == SET_LAST);
      new_roll     = (state == CAPTURE);
   end

   // Held roll word. roll_in is only looked at on the capture edge, by which
   // point the receiver has had SETTLE_CYC cycles to become stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         roll_q     <= '0;
         roll_valid <= 1'b0;
      end else if (capture_load) begin
         roll_q     <= roll_in;
         roll_valid <= 1'b1;
      end
   end

   assign scan_tick = (refresh_cnt == REF_LAST);

   // Scan timebase. Runs freely and is never disturbed by captures, so the
   // refresh rhythm stays even while new words arrive.
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt <= '0;
         digit_idx   <= 2'd0;
         load_disp   <= 1'b0;
      end else begin
         load_disp <= scan_tick;
         if (scan_tick) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
         end else begin
            refresh_cnt <= refresh_cnt + REF_W'(1);
         end
      end
   end

   assign cur_nybble = nybble_at(roll_q, digit_idx);

   hex7seg u_hex7seg (
      .nybble (cur_nybble),
      .seg    (hex_seg)
   );

   // Content for the digit now selected: dashes until a roll exists, then
   // hex, optionally blanking leading zeros. Digit 0 is never blanked so a
   // zero roll still shows a single "0".
   always_comb begin
      digit_seg = hex_seg;
      if (!roll_valid) begin
         digit_seg = SEG_DASH;
      end else if ((BLANK_LZ != 0) && (digit_idx != 2'd0) && upper_zero(roll_q, digit_idx)) begin
         digit_seg = SEG_BLANK;
      end
   end

   // Output registers. Anode and segments change together only in the cycle
   // after the digit index advances, so each digit is a steady snapshot and a
   // mid-dwell capture appears at the next digit refresh.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= SEG_DASH;
         an  <= 4'b1110;
      end else if (load_disp) begin
         seg <= digit_seg;
         an  <= ~(4'b0001 << digit_idx);
      end
   end

endmodule

// File: tb/tb_roll_display_scan.sv
// ---------------------------------------------------------------------------
// tb_roll_display_scan
// Drives two instances of roll_display_scan (BLANK_LZ=1 and BLANK_LZ=0) from
// the same clock, reset, nss and roll word, and checks both against
// hand-computed segment codes and a time-based model of the digit scan.
// ---------------------------------------------------------------------------
module tb_roll_display_scan;

   localparam int REFRESH_DIV = 4;
   localparam int SETTLE_CYC  = 4;

   localparam logic [6:0] SEG_0  = 7'h40;
   localparam logic [6:0] SEG_1  = 7'h79;
   localparam logic [6:0] SEG_2  = 7'h24;
   localparam logic [6:0] SEG_3  = 7'h30;
   localparam logic [6:0] SEG_4  = 7'h19;
   localparam logic [6:0] SEG_5  = 7'h12;
   localparam logic [6:0] SEG_6  = 7'h02;
   localparam logic [6:0] SEG_7  = 7'h78;
   localparam logic [6:0] SEG_8  = 7'h00;
   localparam logic [6:0] SEG_9  = 7'h10;
   localparam logic [6:0] SEG_A  = 7'h08;
   localparam logic [6:0] SEG_B  = 7'h03;
   localparam logic [6:0] SEG_C  = 7'h46;
   localparam logic [6:0] SEG_D  = 7'h21;
   localparam logic [6:0] SEG_E  = 7'h06;
   localparam logic [6:0] SEG_F  = 7'h0E;
   localparam logic [6:0] SEG_BL = 7'h7F;
   localparam logic [6:0] SEG_DS = 7'h3F;

   typedef struct packed {
      logic [15:0]     word;
      logic [3:0][6:0] lz;
      logic [3:0][6:0] all;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        nss_async;
   logic [15:0] roll_in;

   logic [6:0]  seg_lz, seg_all;
   logic [3:0]  an_lz, an_all;
   logic        valid_lz, valid_all;
   logic        new_lz, new_all;

   int n_vec = 0;
   int n_bad = 0;
   int m_cnt = 0;

   vec_t vecs [7];

   roll_display_scan #(
      .REFRESH_DIV (REFRESH_DIV),
      .SETTLE_CYC  (SETTLE_CYC),
      .BLANK_LZ    (1)
   ) dut_lz (
      .clk        (clk),
      .rst        (rst),
      .nss_async  (nss_async),
      .roll_in    (roll_in),
      .seg        (seg_lz),
      .an         (an_lz),
      .roll_valid (valid_lz),
      .new_roll   (new_lz)
   );

   roll_display_scan #(
      .REFRESH_DIV (REFRESH_DIV),
      .SETTLE_CYC  (SETTLE_CYC),
      .BLANK_LZ    (0)
   ) dut_all (
      .clk        (clk),
      .rst        (rst),
      .nss_async  (nss_async),
      .roll_in    (roll_in),
      .seg        (seg_all),
      .an         (an_all),
      .roll_valid (valid_all),
      .new_roll   (new_all)
   );

   always #5 clk = ~clk;

   // Edges since the last reset edge; the scan is a pure function of this.
   always @(posedge clk) begin
      if (rst) m_cnt <= 0;
      else     m_cnt <= m_cnt + 1;
   end

   // Digit lit after edge m: digit 0 through edge 4, then each for 4 edges.
   function automatic int exp_digit(input int m);
      return (m == 0) ? 0 : ((m - 1) / REFRESH_DIV) % 4;
   endfunction

   function automatic logic [3:0] exp_an(input int m);
      logic [3:0] a;
      a = 4'b1111;
      a[exp_digit(m)] = 1'b0;
      return a;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drop nss with a new word and check the new_roll pulse lands exactly
   // on the 7th edge (2 sync edges + settle + capture) and only there.
   task automatic applyStimulus(input logic [15:0] word);
      roll_in   = word;
      nss_async = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         checkOutput("new_roll_lz", 16'(new_lz), 16'(k == 7));
         checkOutput("new_roll_all", 16'(new_all), 16'(k == 7));
      end
      checkOutput("roll_valid_lz", 16'(valid_lz), 16'd1);
      checkOutput("roll_valid_all", 16'(valid_all), 16'd1);
      nss_async = 1'b1;
      repeat (3) tick();
   endtask

   // One full scan of both instances against expected digit codes.
   task automatic check_scan(input logic [3:0][6:0] lz, input logic [3:0][6:0] all);
      int d;
      for (int c = 0; c < 4 * REFRESH_DIV; c++) begin
         tick();
         d = exp_digit(m_cnt);
         checkOutput("an_lz", 16'(an_lz), 16'(exp_an(m_cnt)));
         checkOutput("an_all", 16'(an_all), 16'(exp_an(m_cnt)));
         checkOutput("seg_lz", 16'(seg_lz), 16'(lz[d]));
         checkOutput("seg_all", 16'(seg_all), 16'(all[d]));
      end
   endtask

   task automatic check_reset_values;
      checkOutput("rst_an_lz", 16'(an_lz), 16'h000E);
      checkOutput("rst_an_all", 16'(an_all), 16'h000E);
      checkOutput("rst_seg_lz", 16'(seg_lz), 16'(SEG_DS));
      checkOutput("rst_seg_all", 16'(seg_all), 16'(SEG_DS));
      checkOutput("rst_valid", 16'({valid_lz, valid_all}), 16'd0);
      checkOutput("rst_new", 16'({new_lz, new_all}), 16'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{word: 16'h1A2F, lz: {SEG_1, SEG_A, SEG_2, SEG_F},   all: {SEG_1, SEG_A, SEG_2, SEG_F}};
      vecs[1] = '{word: 16'h0030, lz: {SEG_BL, SEG_BL, SEG_3, SEG_0}, all: {SEG_0, SEG_0, SEG_3, SEG_0}};
      vecs[2] = '{word: 16'h0000, lz: {SEG_BL, SEG_BL, SEG_BL, SEG_0}, all: {SEG_0, SEG_0, SEG_0, SEG_0}};
      vecs[3] = '{word: 16'h8B07, lz: {SEG_8, SEG_B, SEG_0, SEG_7},   all: {SEG_8, SEG_B, SEG_0, SEG_7}};
      vecs[4] = '{word: 16'h00C5, lz: {SEG_BL, SEG_BL, SEG_C, SEG_5}, all: {SEG_0, SEG_0, SEG_C, SEG_5}};
      vecs[5] = '{word: 16'h0E00, lz: {SEG_BL, SEG_E, SEG_0, SEG_0},  all: {SEG_0, SEG_E, SEG_0, SEG_0}};
      vecs[6] = '{word: 16'h4D69, lz: {SEG_4, SEG_D, SEG_6, SEG_9},   all: {SEG_4, SEG_D, SEG_6, SEG_9}};

      // Reset and idle: dashes everywhere, anodes walking.
      rst       = 1'b1;
      nss_async = 1'b1;
      roll_in   = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_reset_values();
      for (int c = 0; c < 64; c++) begin
         tick();
         checkOutput("idle_an_lz", 16'(an_lz), 16'(exp_an(m_cnt)));
         checkOutput("idle_an_all", 16'(an_all), 16'(exp_an(m_cnt)));
         checkOutput("idle_seg_lz", 16'(seg_lz), 16'(SEG_DS));
         checkOutput("idle_seg_all", 16'(seg_all), 16'(SEG_DS));
         checkOutput("idle_valid", 16'({valid_lz, valid_all}), 16'd0);
      end

      // Table of captured words and their digit images.
      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].word);
         repeat (20) tick();
         check_scan(vecs[v].lz, vecs[v].all);
      end

      // nss bounce: fall, rise, fall again. Only the second word is taken,
      // with the pulse timed from the second detected fall (edge 9).
      roll_in   = 16'h7777;
      nss_async = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         checkOutput("bounce_new_lz", 16'(new_lz), 16'(k == 9));
         checkOutput("bounce_new_all", 16'(new_all), 16'(k == 9));
         if (k == 1) nss_async = 1'b1;
         if (k == 2) begin
            nss_async = 1'b0;
            roll_in   = 16'h2222;
         end
      end
      nss_async = 1'b1;
      repeat (20) tick();
      check_scan({SEG_2, SEG_2, SEG_2, SEG_2}, {SEG_2, SEG_2, SEG_2, SEG_2});

      // Capture landing while digit 2 is mid-dwell: digit 2 keeps the old
      // 1A2F image, digit 3 picks up the new 5B3C word, scan unbroken.
      applyStimulus(16'h1A2F);
      repeat (20) tick();
      for (int g = 0; g < 16 && (m_cnt % 16) != 3; g++) tick();
      checkOutput("mid_align", 16'(m_cnt % 16), 16'd3);
      roll_in   = 16'h5B3C;
      nss_async = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         tick();
         checkOutput("mid_an_lz", 16'(an_lz), 16'(exp_an(m_cnt)));
         checkOutput("mid_new_lz", 16'(new_lz), 16'(k == 7));
         if (k >= 7 && k <= 9) begin
            checkOutput("mid_old_an", 16'(an_lz), 16'h000B);
            checkOutput("mid_old_seg_lz", 16'(seg_lz), 16'(SEG_A));
            checkOutput("mid_old_seg_all", 16'(seg_all), 16'(SEG_A));
         end
         if (k == 10) begin
            checkOutput("mid_new_an", 16'(an_lz), 16'h0007);
            checkOutput("mid_new_seg_lz", 16'(seg_lz), 16'(SEG_5));
            checkOutput("mid_new_seg_all", 16'(seg_all), 16'(SEG_5));
         end
         if (k == 14) begin
            checkOutput("mid_d0_an", 16'(an_all), 16'h000E);
            checkOutput("mid_d0_seg_all", 16'(seg_all), 16'(SEG_C));
         end
         if (k == 9) nss_async = 1'b1;
      end

      // Reset in the middle of SETTLE discards the pending capture.
      repeat (4) tick();
      roll_in   = 16'h9999;
      nss_async = 1'b0;
      repeat (4) tick();
      rst       = 1'b1;
      nss_async = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_values();
      for (int c = 0; c < 12; c++) begin
         tick();
         checkOutput("post_rst_new", 16'({new_lz, new_all}), 16'd0);
         checkOutput("post_rst_valid", 16'({valid_lz, valid_all}), 16'd0);
         checkOutput("post_rst_seg", 16'(seg_lz), 16'(SEG_DS));
         checkOutput("post_rst_an", 16'(an_all), 16'(exp_an(m_cnt)));
      end

      $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
